// File: rtl/core_lsu_queue.sv
// core_lsu_queue: in-order load/store request queue in front of a single-port memory.
// Requests are issued strictly FIFO from registered head outputs. Loads return data
// one cycle after completion. A sticky flag reports memory waits that exceed TIMEOUT.
module core_lsu_queue #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    input  logic                         req_is_st,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         req_ready,
    output logic                         ld_resp_valid,
    output logic [DATA_W-1:0]            ld_resp_data,
    output logic [1:0]                   enable_M,
    output logic [ADDR_W-1:0]            addr_M,
    output logic [DATA_W-1:0]            wr_data_M,
    input  logic [DATA_W-1:0]            rd_data_M,
    input  logic                         ready_M,
    output logic                         idle,
    output logic [$clog2(DEPTH):0]       pending_lds,
    output logic                         timeout_err
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic              is_st;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t              r_mem [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_pending;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_timeout_err;
    logic                r_req_ready;
    logic                r_ld_resp_valid;
    logic [DATA_W-1:0]   r_ld_resp_data;
    logic [1:0]          r_enable_M;
    logic [ADDR_W-1:0]   r_addr_M;
    logic [DATA_W-1:0]   r_wr_data_M;
    logic                r_idle;

    logic                w_push;
    logic                w_pop;
    logic                w_ld_pop;
    logic [PTR_W-1:0]    w_head_nxt;
    logic [PTR_W-1:0]    w_tail_nxt;
    logic                w_empty_nxt;
    logic                w_full_nxt;
    entry_t              w_req_entry;
    entry_t              w_nxt_entry;
    logic [CNT_W-1:0]    w_pending_nxt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                w_err_nxt;

    // Next-state of pointers, counters and the entry to present after this edge
    always_comb begin
        w_push        = req_valid & r_req_ready;
        w_pop         = (r_enable_M != 2'b00) & ready_M;
        w_ld_pop      = w_pop & r_enable_M[0];
        w_head_nxt    = r_head + PTR_W'(w_pop);
        w_tail_nxt    = r_tail + PTR_W'(w_push);
        w_empty_nxt   = (w_head_nxt == w_tail_nxt);
        w_full_nxt    = (w_head_nxt[IDX_W-1:0] == w_tail_nxt[IDX_W-1:0]) &
                        (w_head_nxt[IDX_W] != w_tail_nxt[IDX_W]);
        w_req_entry   = '{is_st: req_is_st, addr: req_addr, data: req_wdata};
        // The new head is the slot being written this edge when the queue was empty
        // or held a single popped entry; bypass the array write in that case.
        if (w_push && (w_head_nxt[IDX_W-1:0] == r_tail[IDX_W-1:0])) begin
            w_nxt_entry = w_req_entry;
        end else begin
            w_nxt_entry = r_mem[w_head_nxt[IDX_W-1:0]];
        end
        w_pending_nxt = r_pending + CNT_W'(w_push & ~req_is_st) - CNT_W'(w_ld_pop);
        w_wait_nxt    = r_wait;
        if (w_pop) begin
            w_wait_nxt = '0;
        end else if ((r_enable_M != 2'b00) && (r_wait != '1)) begin
            w_wait_nxt = r_wait + WAIT_W'(1);
        end
        w_err_nxt     = r_timeout_err |
                        ((TIMEOUT != 0) && (w_wait_nxt == WAIT_W'(TIMEOUT)));
    end

    // Queue storage; contents are only meaningful between head and tail
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail[IDX_W-1:0]] <= w_req_entry;
        end
    end

    // Pointers, counters, status and registered memory/response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_pending       <= '0;
            r_wait          <= '0;
            r_timeout_err   <= 1'b0;
            r_req_ready     <= 1'b1;
            r_ld_resp_valid <= 1'b0;
            r_ld_resp_data  <= '0;
            r_enable_M      <= 2'b00;
            r_addr_M        <= '0;
            r_wr_data_M     <= '0;
            r_idle          <= 1'b1;
        end else begin
            r_head          <= w_head_nxt;
            r_tail          <= w_tail_nxt;
            r_pending       <= w_pending_nxt;
            r_wait          <= w_wait_nxt;
            r_timeout_err   <= w_err_nxt;
            r_req_ready     <= ~w_full_nxt & ~w_err_nxt;
            r_ld_resp_valid <= w_ld_pop;
            r_idle          <= w_empty_nxt & ~w_ld_pop;
            if (w_ld_pop) begin
                r_ld_resp_data <= rd_data_M;
            end
            if (w_empty_nxt) begin
                r_enable_M <= 2'b00;
            end else begin
                r_enable_M  <= w_nxt_entry.is_st ? 2'b10 : 2'b01;
                r_addr_M    <= w_nxt_entry.addr;
                r_wr_data_M <= w_nxt_entry.data;
            end
        end
    end

    assign req_ready     = r_req_ready;
    assign ld_resp_valid = r_ld_resp_valid;
    assign ld_resp_data  = r_ld_resp_data;
    assign enable_M      = r_enable_M;
    assign addr_M        = r_addr_M;
    assign wr_data_M     = r_wr_data_M;
    assign idle          = r_idle;
    assign pending_lds   = r_pending;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_core_lsu_queue.sv
// tb_core_lsu_queue: directed checks of the load/store queue with DEPTH=4, TIMEOUT=8.
module tb_core_lsu_queue;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_is_st;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              ld_resp_valid;
    logic [DATA_W-1:0] ld_resp_data;
    logic [1:0]        enable_M;
    logic [ADDR_W-1:0] addr_M;
    logic [DATA_W-1:0] wr_data_M;
    logic [DATA_W-1:0] rd_data_M;
    logic              ready_M;
    logic              idle;
    logic [2:0]        pending_lds;
    logic              timeout_err;

    int n_total = 0;
    int n_bad   = 0;
    logic [DATA_W-1:0] mem_val;

    core_lsu_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_is_st    (req_is_st),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .ld_resp_valid(ld_resp_valid),
        .ld_resp_data (ld_resp_data),
        .enable_M     (enable_M),
        .addr_M       (addr_M),
        .wr_data_M    (wr_data_M),
        .rd_data_M    (rd_data_M),
        .ready_M      (ready_M),
        .idle         (idle),
        .pending_lds  (pending_lds),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are stable 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic st, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        req_valid = v;
        req_is_st = st;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        reset     = 1'b1;
        ready_M   = 1'b0;
        rd_data_M = '0;
        drive_req(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        check("rst_enable", 32'(enable_M), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_idle", 32'(idle), 32'h1);
        check("rst_lddata", 32'(ld_resp_data), 32'h0);
        check("rst_addr", 32'(addr_M), 32'h0);
        check("rst_wdata", 32'(wr_data_M), 32'h0);
        check("rst_pending", 32'(pending_lds), 32'h0);
        check("rst_tmo", 32'(timeout_err), 32'h0);
        reset = 1'b0;
        tick();

        // Single load: push 0x105, memory completes in cycle 2 with 0x3C
        drive_req(1'b1, 1'b0, 12'h105, 8'h00);
        tick();
        drive_req(1'b0, 1'b0, '0, '0);
        check("ld1_c1_en", 32'(enable_M), 32'h1);
        check("ld1_c1_addr", 32'(addr_M), 32'h105);
        check("ld1_c1_pend", 32'(pending_lds), 32'h1);
        check("ld1_c1_idle", 32'(idle), 32'h0);
        check("ld1_c1_rv", 32'(ld_resp_valid), 32'h0);
        tick();
        check("ld1_c2_en", 32'(enable_M), 32'h1);
        check("ld1_c2_addr", 32'(addr_M), 32'h105);
        check("ld1_c2_rv", 32'(ld_resp_valid), 32'h0);
        ready_M   = 1'b1;
        rd_data_M = 8'h3C;
        tick();
        ready_M   = 1'b0;
        rd_data_M = 8'h00;
        check("ld1_c3_rv", 32'(ld_resp_valid), 32'h1);
        check("ld1_c3_data", 32'(ld_resp_data), 32'h3C);
        check("ld1_c3_en", 32'(enable_M), 32'h0);
        check("ld1_c3_pend", 32'(pending_lds), 32'h0);
        check("ld1_c3_idle", 32'(idle), 32'h0);
        tick();
        check("ld1_c4_rv", 32'(ld_resp_valid), 32'h0);
        check("ld1_c4_data", 32'(ld_resp_data), 32'h3C);
        check("ld1_c4_idle", 32'(idle), 32'h1);

        // Fill: four stores with the memory stalled
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill_rdy%0d", i), 32'(req_ready), 32'h1);
            drive_req(1'b1, 1'b1, 12'(12'h200 + i), 8'(8'h10 + i));
            tick();
        end
        drive_req(1'b0, 1'b0, '0, '0);
        check("fill_full_rdy", 32'(req_ready), 32'h0);
        check("fill_en", 32'(enable_M), 32'h2);
        check("fill_addr", 32'(addr_M), 32'h200);
        check("fill_wd", 32'(wr_data_M), 32'h10);
        tick();
        check("fill_hold_en", 32'(enable_M), 32'h2);
        check("fill_hold_addr", 32'(addr_M), 32'h200);
        check("fill_hold_wd", 32'(wr_data_M), 32'h10);
        check("fill_hold_rdy", 32'(req_ready), 32'h0);
        ready_M = 1'b1;
        tick();
        ready_M = 1'b0;
        check("fill_pop_rdy", 32'(req_ready), 32'h1);
        check("fill_pop_addr", 32'(addr_M), 32'h201);
        check("fill_pop_wd", 32'(wr_data_M), 32'h11);
        ready_M = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check($sformatf("drain_addr%0d", i), 32'(addr_M), 32'(12'h200 + i));
            check($sformatf("drain_wd%0d", i), 32'(wr_data_M), 32'(8'h10 + i));
            tick();
        end
        ready_M = 1'b0;
        check("drain_en", 32'(enable_M), 32'h0);
        check("drain_idle", 32'(idle), 32'h1);
        check("drain_rv", 32'(ld_resp_valid), 32'h0);

        // Ordering: store 0xAA to 0x010 then load 0x010
        drive_req(1'b1, 1'b1, 12'h010, 8'hAA);
        tick();
        drive_req(1'b1, 1'b0, 12'h010, 8'h00);
        tick();
        drive_req(1'b0, 1'b0, '0, '0);
        check("ord_st_en", 32'(enable_M), 32'h2);
        check("ord_st_addr", 32'(addr_M), 32'h010);
        check("ord_st_wd", 32'(wr_data_M), 32'hAA);
        check("ord_pend1", 32'(pending_lds), 32'h1);
        mem_val = wr_data_M;
        ready_M = 1'b1;
        tick();
        check("ord_ld_en", 32'(enable_M), 32'h1);
        check("ord_ld_addr", 32'(addr_M), 32'h010);
        rd_data_M = mem_val;
        tick();
        ready_M   = 1'b0;
        rd_data_M = 8'h00;
        check("ord_rv", 32'(ld_resp_valid), 32'h1);
        check("ord_data", 32'(ld_resp_data), 32'hAA);
        check("ord_pend0", 32'(pending_lds), 32'h0);
        tick();

        // Streaming loads at occupancy 2: one push and one pop every edge
        drive_req(1'b1, 1'b0, 12'h300, 8'h00);
        tick();
        drive_req(1'b1, 1'b0, 12'h301, 8'h00);
        tick();
        for (int j = 0; j < 10; j++) begin
            check($sformatf("str_addr%0d", j), 32'(addr_M), 32'(12'h300 + j));
            check($sformatf("str_pend%0d", j), 32'(pending_lds), 32'h2);
            check($sformatf("str_rdy%0d", j), 32'(req_ready), 32'h1);
            if (j > 0) begin
                check($sformatf("str_rdata%0d", j), 32'(ld_resp_data), 32'(8'h40 + j - 1));
            end
            drive_req(1'b1, 1'b0, 12'(12'h302 + j), 8'h00);
            ready_M   = 1'b1;
            rd_data_M = 8'(8'h40 + j);
            tick();
        end
        ready_M   = 1'b0;
        rd_data_M = 8'h00;
        drive_req(1'b1, 1'b0, 12'h30C, 8'h00);
        tick();
        drive_req(1'b1, 1'b0, 12'h30D, 8'h00);
        tick();
        drive_req(1'b0, 1'b0, '0, '0);
        check("str_full_rdy", 32'(req_ready), 32'h0);
        check("str_full_pend", 32'(pending_lds), 32'h4);
        ready_M = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("str_tail_addr%0d", k), 32'(addr_M), 32'(12'h30A + k));
            tick();
        end
        ready_M = 1'b0;
        check("str_end_pend", 32'(pending_lds), 32'h0);
        tick();
        check("str_end_idle", 32'(idle), 32'h1);

        // Timeout: one load with the memory never completing
        drive_req(1'b1, 1'b0, 12'h0F0, 8'h00);
        tick();
        drive_req(1'b0, 1'b0, '0, '0);
        for (int c = 1; c < 8; c++) begin
            tick();
        end
        check("tmo_before", 32'(timeout_err), 32'h0);
        check("tmo_before_rdy", 32'(req_ready), 32'h1);
        tick();
        check("tmo_set", 32'(timeout_err), 32'h1);
        check("tmo_rdy", 32'(req_ready), 32'h0);
        check("tmo_en_held", 32'(enable_M), 32'h1);
        check("tmo_addr_held", 32'(addr_M), 32'h0F0);
        ready_M = 1'b1;
        tick();
        ready_M = 1'b0;
        tick();
        tick();
        check("tmo_sticky", 32'(timeout_err), 32'h1);
        check("tmo_sticky_rdy", 32'(req_ready), 32'h0);
        reset = 1'b1;
        #1;
        check("tmo_clr", 32'(timeout_err), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Asynchronous reset with a load in flight and three entries queued
        drive_req(1'b1, 1'b0, 12'h400, 8'h00);
        tick();
        drive_req(1'b1, 1'b1, 12'h401, 8'h55);
        tick();
        drive_req(1'b1, 1'b1, 12'h402, 8'h66);
        tick();
        drive_req(1'b0, 1'b0, '0, '0);
        check("ar_pre_en", 32'(enable_M), 32'h1);
        check("ar_pre_pend", 32'(pending_lds), 32'h1);
        ready_M   = 1'b1;
        rd_data_M = 8'h77;
        #2;
        reset = 1'b1;
        #1;
        check("ar_en", 32'(enable_M), 32'h0);
        check("ar_idle", 32'(idle), 32'h1);
        check("ar_rdy", 32'(req_ready), 32'h1);
        check("ar_pend", 32'(pending_lds), 32'h0);
        check("ar_lddata", 32'(ld_resp_data), 32'h0);
        check("ar_addr", 32'(addr_M), 32'h0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("ar_post_rv%0d", c), 32'(ld_resp_valid), 32'h0);
            check($sformatf("ar_post_en%0d", c), 32'(enable_M), 32'h0);
            check($sformatf("ar_post_idle%0d", c), 32'(idle), 32'h1);
        end
        ready_M   = 1'b0;
        rd_data_M = 8'h00;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
